pc_select_ctrl: RTL and testbench

//  Next-PC source selector for the fetch stage, with tracking of outstanding predicted branches.
//  - Chooses between PC+4, the predicted target, the direct target and the reservation-station redirect.
//  - Bounds the number of in-flight predicted branches and stalls fetch at the limit.
//  - After a rollback, forces PC+4 for a programmable recovery window.
//  - Sits between decode/issue and the PC mux; consumes the issue-stage operand tags and the branch-resolution events.

---
 rtl/pc_sel_pkg.sv | 20 ++
 rtl/branch_pending_ctr.sv | 34 +++
 rtl/pc_select_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_select_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sel_pkg.sv
// Shared encodings for the fetch-stage next-PC selector: mux select codes,
// branch opcode field values and the recovery FSM state type.
package pc_sel_pkg;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_PRED   = 2'b01;
  localparam logic [1:0] SEL_DIRECT = 2'b10;
  localparam logic [1:0] SEL_RS     = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_JAL  = 2'b01;
  localparam logic [1:0] BR_JR   = 2'b10;
  localparam logic [1:0] BR_J    = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } pc_sel_state_t;

endpackage

// File: rtl/branch_pending_ctr.sv
// Saturating up/down counter of unresolved predicted branches, with a
// synchronous clear that overrides both count directions.
module branch_pending_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic inc_ok;
  logic dec_ok;

  // Guards keep the count inside [0, MAX] even if a caller misbehaves.
  assign inc_ok = inc && (cnt != W'(MAX));
  assign dec_ok = dec && (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/pc_select_ctrl.sv
// Next-PC source selector for fetch: picks PC+4 / predicted / direct / RS
// redirect, bounds in-flight predicted branches and holds PC+4 after rollback.
module pc_select_ctrl
  import pc_sel_pkg::*;
#(
  parameter int TAG_W          = 5,
  parameter int MAX_PENDING    = 4,
  parameter int RECOVER_CYCLES = 1,
  parameter int CNT_W          = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_issue,
  input  logic [1:0]       branch_op,
  input  logic [TAG_W-1:0] qj,
  input  logic [TAG_W-1:0] qk,
  input  logic             rollback,
  input  logic             resolve,
  output logic [1:0]       sel,
  output logic             stall,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             recover_busy
);

  localparam int RC_W_RAW = $clog2(RECOVER_CYCLES + 1);
  localparam int RC_W     = (RC_W_RAW < 2) ? 2 : RC_W_RAW;
  localparam int RC_LOAD  = (RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0;

  pc_sel_state_t    state;
  pc_sel_state_t    state_nxt;
  logic [RC_W-1:0]  rc;
  logic [RC_W-1:0]  rc_nxt;

  logic is_br;
  logic dep;
  logic full;
  logic cnt_inc;
  logic cnt_dec;

  assign is_br = branch_issue || (branch_op != BR_NONE);
  assign dep   = (qj != '0) || (qk != '0);
  assign full  = (pending_cnt == CNT_W'(MAX_PENDING));

  // Select priority: reset, redirect, recovery window, then branch kind.
  always_comb begin
    sel   = SEL_SEQ;
    stall = 1'b0;
    if (rst) begin
      sel = SEL_SEQ;
    end else if (rollback) begin
      sel = SEL_RS;
    end else if (state == ST_RECOVER) begin
      sel = SEL_SEQ;
    end else if (!is_br) begin
      sel = SEL_SEQ;
    end else if (dep && full) begin
      sel   = SEL_SEQ;
      stall = 1'b1;
    end else if (dep) begin
      sel = SEL_PRED;
    end else begin
      sel = SEL_DIRECT;
    end
  end

  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    case (state)
      ST_IDLE: begin
        if (rollback && (RECOVER_CYCLES > 0)) begin
          state_nxt = ST_RECOVER;
          rc_nxt    = RC_W'(RC_LOAD);
        end
      end
      ST_RECOVER: begin
        // A fresh rollback restarts the whole window.
        if (rollback) begin
          rc_nxt = RC_W'(RC_LOAD);
        end else if (rc == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          rc_nxt = rc - RC_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rc           <= '0;
      recover_busy <= 1'b0;
    end else begin
      state        <= state_nxt;
      rc           <= rc_nxt;
      recover_busy <= (state_nxt == ST_RECOVER);
    end
  end

  assign cnt_inc = (sel == SEL_PRED);
  assign cnt_dec = resolve && (pending_cnt != '0);

  branch_pending_ctr #(
    .MAX (MAX_PENDING),
    .W   (CNT_W)
  ) u_pending (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .dec (cnt_dec),
    .clr (rollback),
    .cnt (pending_cnt)
  );

endmodule

// File: tb/tb_pc_select_ctrl.sv
// Directed-vector bench for pc_select_ctrl (TAG_W=5, MAX_PENDING=4,
// RECOVER_CYCLES=2) with hand-computed expectations.
module tb_pc_select_ctrl;

  logic       clk;
  logic       rst;
  logic       branch_issue;
  logic [1:0] branch_op;
  logic [4:0] qj;
  logic [4:0] qk;
  logic       rollback;
  logic       resolve;
  logic [1:0] sel;
  logic       stall;
  logic [2:0] pending_cnt;
  logic       recover_busy;

  int n_tests;
  int n_fail;

  pc_select_ctrl #(
    .TAG_W          (5),
    .MAX_PENDING    (4),
    .RECOVER_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_issue (branch_issue),
    .branch_op    (branch_op),
    .qj           (qj),
    .qk           (qk),
    .rollback     (rollback),
    .resolve      (resolve),
    .sel          (sel),
    .stall        (stall),
    .pending_cnt  (pending_cnt),
    .recover_busy (recover_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] j, input logic [4:0] k,
                       input logic rb, input logic res);
    branch_issue = 1'b0;
    branch_op    = op;
    qj           = j;
    qk           = k;
    rollback     = rb;
    resolve      = res;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rst_sel", sel, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_busy", recover_busy, 0);
    tick();
    tick();
    rst = 1'b0;

    // Direct jump, no dependency
    drive(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("direct_sel", sel, 2);
    chk("direct_stall", stall, 0);
    tick();
    chk("direct_pending", pending_cnt, 0);

    // Predicted jr with dependency
    drive(2'b10, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("pred_sel", sel, 1);
    tick();
    chk("pred_pending", pending_cnt, 1);

    // Fill to MAX_PENDING
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 5'd5, 5'd0, 1'b0, 1'b0);
      chk("fill_sel", sel, 1);
      tick();
    end
    chk("full_pending", pending_cnt, 4);

    drive(2'b10, 5'd0, 5'd3, 1'b0, 1'b0);
    chk("full_sel", sel, 0);
    chk("full_stall", stall, 1);
    tick();
    chk("full_hold", pending_cnt, 4);

    drive(2'b10, 5'd0, 5'd3, 1'b0, 1'b1);
    chk("full_res_stall", stall, 1);
    chk("full_res_sel", sel, 0);
    tick();
    chk("full_res_pending", pending_cnt, 3);

    // Rollback with a two-cycle recovery window
    drive(2'b11, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("rb_sel", sel, 3);
    chk("rb_stall", stall, 0);
    tick();
    drive(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rec1_sel", sel, 0);
    chk("rec1_busy", recover_busy, 1);
    chk("rec1_pending", pending_cnt, 0);
    tick();
    chk("rec2_sel", sel, 0);
    chk("rec2_busy", recover_busy, 1);
    tick();
    chk("rec3_sel", sel, 2);
    chk("rec3_busy", recover_busy, 0);

    // Simultaneous increment and resolve
    drive(2'b01, 5'd1, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("sim_pre", pending_cnt, 2);
    drive(2'b01, 5'd1, 5'd0, 1'b0, 1'b1);
    chk("sim_sel", sel, 1);
    tick();
    chk("sim_pending", pending_cnt, 2);
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("none_sel", sel, 0);
    tick();
    tick();
    chk("res_to_zero", pending_cnt, 0);
    tick();
    chk("res_at_zero", pending_cnt, 0);

    // Rollback inside the window reloads it
    drive(2'b11, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(2'b11, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("reload_rb_sel", sel, 3);
    tick();
    drive(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("reload1_sel", sel, 0);
    tick();
    chk("reload2_sel", sel, 0);
    chk("reload2_busy", recover_busy, 1);
    tick();
    chk("reload3_sel", sel, 2);

    // Asynchronous reset in the middle of the window
    drive(2'b11, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("arst_pre_busy", recover_busy, 1);
    #1;
    rst = 1'b1;
    rollback = 1'b1;
    #1;
    chk("arst_busy", recover_busy, 0);
    chk("arst_sel", sel, 0);
    tick();
    rollback = 1'b0;
    rst = 1'b0;
    drive(2'b10, 5'd2, 5'd0, 1'b0, 1'b0);
    chk("post_rst_sel", sel, 1);
    tick();
    chk("post_rst_pending", pending_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
